// File: rtl/uart_frame_parser_if.sv
// ---------------------------------------------------------------------------
// uart_frame_parser_if
//   Bundles the byte-receiver strobe, the payload valid/ready stream and the
//   frame status signals between the frame parser and its environment.
//
//   master : the parser side (consumes rx strobes, drives stream and status)
//   slave  : the environment side (UART receiver plus application consumer)
//
//   i_rxFlag    one-cycle strobe, i_rxByte holds a new byte
//   i_rxByte    received byte
//   o_data      payload byte offered downstream
//   o_dataValid o_data is valid
//   i_dataReady downstream accepts o_data this cycle
//   o_frameOk   one-cycle pulse, checksum matched
//   o_frameErr  one-cycle pulse, cause in o_errCode
//   o_errCode   00 overrun, 01 bad length, 10 checksum, 11 timeout
//   o_busy      parser is not idle
// ---------------------------------------------------------------------------
interface uart_frame_parser_if;
  logic       i_rxFlag;
  logic [7:0] i_rxByte;
  logic [7:0] o_data;
  logic       o_dataValid;
  logic       i_dataReady;
  logic       o_frameOk;
  logic       o_frameErr;
  logic [1:0] o_errCode;
  logic       o_busy;

  modport master (
    input  i_rxFlag, i_rxByte, i_dataReady,
    output o_data, o_dataValid, o_frameOk, o_frameErr, o_errCode, o_busy
  );

  modport slave (
    output i_rxFlag, i_rxByte, i_dataReady,
    input  o_data, o_dataValid, o_frameOk, o_frameErr, o_errCode, o_busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
//   Assembles UART bytes into frames: SYNC, LEN, LEN payload bytes, CSUM
//   where CSUM = (LEN + sum(payload)) mod 256. Payload is buffered and only
//   released over the valid/ready stream once the checksum has matched.
//   An inter-byte timeout aborts truncated frames.
//
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : uart_frame_parser_if.master (rx strobe/byte, payload stream,
//             frame status pulses, error code, busy)
// ---------------------------------------------------------------------------
module uart_frame_parser #(
  parameter int         MAX_PAYLOAD  = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 25000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  uart_frame_parser_if.master   bus
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [7:0]    MAX_LEN  = 8'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DRAIN} state_t;

  state_t        state_q;
  logic [7:0]    mem [MAX_PAYLOAD];
  logic [AW-1:0] wr_idx_q;
  logic [AW-1:0] rd_idx_q;
  logic [AW-1:0] rd_addr;
  logic [7:0]    len_q;
  logic [7:0]    acc_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ok_q;
  logic          err_q;
  logic [1:0]    code_q;
  logic [TW-1:0] tmo_q;
  logic          wr_en;
  logic          xfer;
  logic          last_wr;
  logic          last_rd;

  assign wr_en   = (state_q == PAYLOAD) && bus.i_rxFlag;
  assign xfer    = valid_q && bus.i_dataReady;
  assign last_wr = (8'(wr_idx_q) == len_q - 8'd1);
  assign last_rd = (8'(rd_idx_q) == len_q - 8'd1);

  // Single read port: the checksum cycle prefetches entry 0, draining
  // prefetches the entry after the one currently offered.
  always_comb begin
    rd_addr = rd_idx_q + 1'b1;
    if (state_q == CSUM) rd_addr = '0;
  end

  // Payload buffer carries no reset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_idx_q] <= bus.i_rxByte;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_OVERRUN;
      tmo_q    <= '0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (bus.i_rxFlag && bus.i_rxByte == SYNC_BYTE) state_q <= LEN;
        end

        LEN, PAYLOAD, CSUM: begin
          // A strobe always beats an expiring timeout in the same cycle.
          if (bus.i_rxFlag) begin
            tmo_q <= '0;
            case (state_q)
              LEN: begin
                if (bus.i_rxByte == 8'd0 || bus.i_rxByte > MAX_LEN) begin
                  err_q   <= 1'b1;
                  code_q  <= ERR_LEN;
                  state_q <= IDLE;
                end else begin
                  len_q    <= bus.i_rxByte;
                  acc_q    <= bus.i_rxByte;
                  wr_idx_q <= '0;
                  state_q  <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                acc_q    <= acc_q + bus.i_rxByte;
                wr_idx_q <= wr_idx_q + 1'b1;
                if (last_wr) state_q <= CSUM;
              end
              default: begin
                if (bus.i_rxByte == acc_q) begin
                  ok_q     <= 1'b1;
                  valid_q  <= 1'b1;
                  data_q   <= mem[rd_addr];
                  rd_idx_q <= '0;
                  state_q  <= DRAIN;
                end else begin
                  err_q   <= 1'b1;
                  code_q  <= ERR_CSUM;
                  state_q <= IDLE;
                end
              end
            endcase
          end else if (tmo_q == TMO_LAST) begin
            tmo_q   <= '0;
            err_q   <= 1'b1;
            code_q  <= ERR_TIMEOUT;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        DRAIN: begin
          // A byte arriving now is dropped unseen; draining is unaffected.
          if (bus.i_rxFlag) begin
            err_q  <= 1'b1;
            code_q <= ERR_OVERRUN;
          end
          if (xfer) begin
            if (last_rd) begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
              data_q   <= mem[rd_addr];
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_dataValid = valid_q;
  assign bus.o_frameOk   = ok_q;
  assign bus.o_frameErr  = err_q;
  assign bus.o_errCode   = code_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule
